// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder: recovers the 16-bit word shown on a time-multiplexed,
// active-low seven-segment display. Each digit must be stable for SETTLE
// edges before its segment pattern is decoded into a hex nibble. Once all
// four digits have been captured, the word is published with a one-cycle
// value_valid pulse. link_lost flags TIMEOUT edges without any capture.
module ssd_scan_decoder #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  seg_in,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        frame_error,
  output logic [3:0]  digit_mask,
  output logic        link_lost
);

  localparam logic [7:0]  SETTLE_C  = 8'(SETTLE);
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  typedef enum logic [1:0] {ST_WAIT, ST_SETTLE, ST_CAPT} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [3:0]  an_prev_reg;
  logic [6:0]  seg_prev_reg;
  logic [3:0]  shadow_reg [4];
  logic        err_reg;
  logic [15:0] idle_reg, idle_next;

  logic        legal;
  logic [1:0]  digit_idx;
  logic [6:0]  seg_on;
  logic [3:0]  nibble;
  logic        bad;
  logic        capture;
  logic        complete;
  logic        timeout_hit;
  logic        same_an, same_seg;

  assign seg_on   = ~seg_in;
  assign same_an  = (an == an_prev_reg);
  assign same_seg = (seg_in == seg_prev_reg);

  // A frame is published on the edge after the last missing digit lands.
  assign complete = (digit_mask == 4'hF);

  // Idle counter saturates at TIMEOUT; a capture always restarts it.
  assign idle_next   = capture ? 16'd0 :
                       (idle_reg == TIMEOUT_C) ? idle_reg : idle_reg + 16'd1;
  assign timeout_hit = !capture && (idle_next == TIMEOUT_C);

  // Classify the anode lines: only a single low bit selects a digit.
  always_comb begin
    legal     = 1'b1;
    digit_idx = 2'd0;
    case (an)
      4'b1110: digit_idx = 2'd0;
      4'b1101: digit_idx = 2'd1;
      4'b1011: digit_idx = 2'd2;
      4'b0111: digit_idx = 2'd3;
      default: legal = 1'b0;
    endcase
  end

  // Map an active-high gfedcba pattern back to its hex digit.
  always_comb begin
    nibble = 4'h0;
    bad    = 1'b0;
    case (seg_on)
      7'h3F: nibble = 4'h0;
      7'h06: nibble = 4'h1;
      7'h5B: nibble = 4'h2;
      7'h4F: nibble = 4'h3;
      7'h66: nibble = 4'h4;
      7'h6D: nibble = 4'h5;
      7'h7D: nibble = 4'h6;
      7'h07: nibble = 4'h7;
      7'h7F: nibble = 4'h8;
      7'h6F: nibble = 4'h9;
      7'h77: nibble = 4'hA;
      7'h7C: nibble = 4'hB;
      7'h39: nibble = 4'hC;
      7'h5E: nibble = 4'hD;
      7'h79: nibble = 4'hE;
      7'h71: nibble = 4'hF;
      default: bad = 1'b1;
    endcase
  end

  // Settle FSM: count identical legal samples, capture once per activation.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    if (!legal) begin
      state_next = ST_WAIT;
      cnt_next   = 8'd0;
    end else begin
      case (state_reg)
        ST_SETTLE: begin
          if (same_an && same_seg) begin
            cnt_next = cnt_reg + 8'd1;
            if (cnt_reg + 8'd1 == SETTLE_C) begin
              capture    = 1'b1;
              state_next = ST_CAPT;
            end
          end else begin
            cnt_next = 8'd1;
          end
        end
        default: begin
          // A zero count means the previous sample was not a legal anode;
          // otherwise only a different anode re-arms after a capture.
          if (cnt_reg == 8'd0 || !same_an) begin
            cnt_next   = 8'd1;
            state_next = ST_SETTLE;
          end else begin
            state_next = ST_WAIT;
          end
        end
      endcase
    end
  end

  // FSM state, settle counter and previous-edge input samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_WAIT;
      cnt_reg      <= 8'd0;
      an_prev_reg  <= 4'hF;
      seg_prev_reg <= 7'h7F;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      an_prev_reg  <= an;
      seg_prev_reg <= seg_in;
    end
  end

  // One shadow nibble per digit, written only by a capture of that digit.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    // Store the decoded nibble when this digit is captured.
    always_ff @(posedge clk) begin
      if (reset) begin
        shadow_reg[gi] <= 4'h0;
      end else if (capture && digit_idx == 2'(gi)) begin
        shadow_reg[gi] <= nibble;
      end
    end
  end

  // Frame bookkeeping: mask, error flag, publication and link supervision.
  always_ff @(posedge clk) begin
    if (reset) begin
      value       <= 16'h0000;
      value_valid <= 1'b0;
      frame_error <= 1'b0;
      digit_mask  <= 4'h0;
      err_reg     <= 1'b0;
      idle_reg    <= 16'd0;
      link_lost   <= 1'b0;
    end else begin
      value_valid <= complete;
      if (complete) begin
        value       <= {shadow_reg[3], shadow_reg[2], shadow_reg[1], shadow_reg[0]};
        frame_error <= err_reg;
      end
      digit_mask <= ((complete || timeout_hit) ? 4'h0 : digit_mask) |
                    (capture ? ~an : 4'h0);
      err_reg    <= ((complete || timeout_hit) ? 1'b0 : err_reg) | (capture & bad);
      idle_reg   <= idle_next;
      if (capture) begin
        link_lost <= 1'b0;
      end else if (timeout_hit) begin
        link_lost <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// tb_ssd_scan_decoder: drives directed display scenarios followed by random
// scanning traffic and checks every output on every cycle against a
// run-length based reference model of the decoder.
module tb_ssd_scan_decoder;

  localparam int SETTLE = 4;
  // A 32-edge timeout keeps the 20-cycle illegal-anode burst inside the window.
  localparam int TO     = 32;

  logic        clk;
  logic        reset;
  logic [3:0]  an;
  logic [6:0]  seg_in;
  logic [15:0] value;
  logic        value_valid;
  logic        frame_error;
  logic [3:0]  digit_mask;
  logic        link_lost;

  ssd_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .an(an), .seg_in(seg_in),
    .value(value), .value_valid(value_valid), .frame_error(frame_error),
    .digit_mask(digit_mask), .link_lost(link_lost)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Active-high gfedcba glyphs for 0..F.
  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  bit chk_en = 1'b0;

  // Reference model state.
  bit         m_prev_legal;
  logic [3:0] m_prev_an;
  logic [6:0] m_prev_seg;
  int         m_run, m_idle;
  bit         m_done, m_err, m_lost, m_pend, m_valid, m_fe;
  logic [3:0] m_seen;
  logic [3:0] m_shadow [4];
  logic [15:0] m_value;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Advance the model by one clock edge with the inputs sampled there.
  task automatic model_step(input logic [3:0] a, input logic [6:0] s, input logic r);
    bit legal, cap, found;
    int pos, nib;
    logic [6:0] on;
    if (r) begin
      m_prev_legal = 0; m_prev_an = 4'hF; m_prev_seg = 7'h7F;
      m_run = 0; m_idle = 0; m_done = 0; m_err = 0; m_lost = 0;
      m_pend = 0; m_valid = 0; m_fe = 0; m_seen = 4'h0; m_value = 16'h0;
      for (int i = 0; i < 4; i++) m_shadow[i] = 4'h0;
    end else begin
      legal = ($countones(~a) == 1);
      m_valid = 0;
      if (m_pend) begin
        m_value = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
        m_fe = m_err; m_valid = 1; m_seen = 4'h0; m_err = 0; m_pend = 0;
      end
      cap = 0;
      if (legal) begin
        if (m_prev_legal && a == m_prev_an) begin
          if (s == m_prev_seg) m_run++;
          else m_run = 1;
        end else begin
          m_run = 1;
          m_done = 0;
        end
        if (m_run == SETTLE && !m_done) begin
          cap = 1;
          m_done = 1;
        end
      end else begin
        m_run = 0;
        m_done = 0;
      end
      if (cap) begin
        on = ~s; nib = 0; found = 0; pos = 0;
        for (int i = 0; i < 16; i++) if (seg_tbl[i] == on) begin nib = i; found = 1; end
        for (int i = 0; i < 4; i++) if (a[i] == 1'b0) pos = i;
        m_shadow[pos] = nib[3:0];
        m_seen[pos] = 1'b1;
        if (!found) m_err = 1;
        m_idle = 0; m_lost = 0;
        if (m_seen == 4'hF) m_pend = 1;
      end else begin
        if (m_idle < TO) m_idle++;
        if (m_idle == TO) begin m_lost = 1; m_seen = 4'h0; m_err = 0; end
      end
      m_prev_legal = legal; m_prev_an = a; m_prev_seg = s;
    end
  endtask

  // One clock: apply inputs, update the model at the edge, count pulses.
  task automatic tick(input logic [3:0] a, input logic [6:0] s);
    an = a;
    seg_in = s;
    @(posedge clk);
    model_step(a, s, reset);
    chk_en = 1'b1;
    #1;
    if (value_valid === 1'b1) pulses++;
  endtask

  // Show raw segment value s on digit d for hold cycles, then blank for gap.
  task automatic show(input int d, input logic [6:0] s, input int hold, input int gap);
    logic [3:0] a;
    a = ~(4'b0001 << d);
    for (int i = 0; i < hold; i++) tick(a, s);
    for (int i = 0; i < gap; i++) tick(4'hF, 7'h7F);
  endtask

  // Compare every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("value", 32'(value), 32'(m_value));
        check("value_valid", 32'(value_valid), 32'(m_valid));
        check("frame_error", 32'(frame_error), 32'(m_fe));
        check("digit_mask", 32'(digit_mask), 32'(m_seen));
        check("link_lost", 32'(link_lost), 32'(m_lost));
      end
    end
  end

  initial begin
    logic [3:0] a;
    int r, n;
    reset = 1'b1;
    an = 4'hF;
    seg_in = 7'h7F;
    tick(4'hF, 7'h7F);
    tick(4'hF, 7'h7F);
    reset = 1'b0;
    check("rst_value", 32'(value), 32'h0);
    check("rst_valid", 32'(value_valid), 32'h0);
    check("rst_ferr", 32'(frame_error), 32'h0);
    check("rst_mask", 32'(digit_mask), 32'h0);
    check("rst_lost", 32'(link_lost), 32'h0);

    // Display 0x1A3F.
    pulses = 0;
    show(0, ~7'h71, 8, 2);
    show(1, ~7'h4F, 8, 2);
    show(2, ~7'h77, 8, 2);
    show(3, ~7'h06, 8, 2);
    check("disp_value", 32'(value), 32'h1A3F);
    check("disp_ferr", 32'(frame_error), 32'h0);
    check("disp_pulses", 32'(pulses), 32'd1);

    // Glitch on digit 2: 2 cycles of "2" then "3".
    pulses = 0;
    show(0, ~7'h6D, 8, 2);
    show(1, ~7'h7D, 8, 2);
    show(2, ~7'h5B, 2, 0);
    show(2, ~7'h4F, 3, 0);
    check("glitch_mask_pre", 32'(digit_mask), 32'h3);
    show(2, ~7'h4F, 1, 0);
    check("glitch_mask_cap", 32'(digit_mask), 32'h7);
    show(2, ~7'h4F, 2, 2);
    show(3, ~7'h07, 8, 2);
    check("glitch_value", 32'(value), 32'h7365);
    check("glitch_pulses", 32'(pulses), 32'd1);

    // Undecodable blank pattern on digit 1 of 0x4321.
    pulses = 0;
    show(0, ~7'h06, 8, 2);
    show(1, 7'h7F, 8, 2);
    show(2, ~7'h4F, 8, 2);
    show(3, ~7'h66, 8, 2);
    check("badpat_value", 32'(value), 32'h4301);
    check("badpat_ferr", 32'(frame_error), 32'h1);
    check("badpat_pulses", 32'(pulses), 32'd1);

    // Illegal two-low anode for 20 cycles.
    pulses = 0;
    show(0, ~7'h3F, 8, 2);
    show(1, ~7'h06, 8, 2);
    for (int i = 0; i < 20; i++) tick(4'b0011, ~7'h5B);
    check("illegal_mask", 32'(digit_mask), 32'h3);
    check("illegal_pulses", 32'(pulses), 32'd0);
    check("illegal_lost", 32'(link_lost), 32'h0);

    // Timeout after two captures.
    show(0, ~7'h3F, 8, 0);
    show(1, ~7'h06, 8, 0);
    for (int i = 0; i < TO - 5; i++) tick(4'hF, 7'h7F);
    check("to_lost_pre", 32'(link_lost), 32'h0);
    check("to_mask_pre", 32'(digit_mask), 32'h3);
    tick(4'hF, 7'h7F);
    check("to_lost", 32'(link_lost), 32'h1);
    check("to_mask", 32'(digit_mask), 32'h0);
    check("to_value", 32'(value), 32'h4301);
    show(2, ~7'h3F, 3, 0);
    check("to_lost_hold", 32'(link_lost), 32'h1);
    show(2, ~7'h3F, 1, 0);
    check("to_lost_clear", 32'(link_lost), 32'h0);
    check("to_mask_new", 32'(digit_mask), 32'h4);
    show(2, ~7'h3F, 4, 2);

    // Reset mid-frame, then frame 0x0007 in reverse digit order.
    show(0, ~7'h3F, 8, 2);
    show(1, ~7'h3F, 8, 2);
    reset = 1'b1;
    tick(4'hF, 7'h7F);
    reset = 1'b0;
    check("mrst_value", 32'(value), 32'h0);
    check("mrst_mask", 32'(digit_mask), 32'h0);
    check("mrst_valid", 32'(value_valid), 32'h0);
    check("mrst_ferr", 32'(frame_error), 32'h0);
    check("mrst_lost", 32'(link_lost), 32'h0);
    pulses = 0;
    show(3, ~7'h3F, 8, 2);
    show(2, ~7'h3F, 8, 2);
    show(1, ~7'h3F, 8, 2);
    check("mrst_mask3", 32'(digit_mask), 32'hE);
    check("mrst_pulses_pre", 32'(pulses), 32'd0);
    show(0, ~7'h07, 8, 2);
    check("mrst_frame", 32'(value), 32'h0007);
    check("mrst_pulses", 32'(pulses), 32'd1);

    // Random scanning traffic, checked cycle by cycle by the model.
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        n = $urandom_range(0, 15);
        show($urandom_range(0, 3),
             ($urandom_range(0, 9) == 0) ? 7'($urandom) : ~seg_tbl[n],
             $urandom_range(1, 9), $urandom_range(0, 3));
      end else if (r < 80) begin
        a = 4'($urandom);
        if ($countones(~a) == 1) a = 4'b0101;
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) tick(a, 7'($urandom));
      end else if (r < 97) begin
        n = $urandom_range(1, 12);
        for (int i = 0; i < n; i++) tick(4'hF, 7'h7F);
      end else if (r < 99) begin
        n = $urandom_range(TO - 2, TO + 12);
        for (int i = 0; i < n; i++) tick(4'hF, 7'h7F);
      end else begin
        reset = 1'b1;
        tick(4'hF, 7'h7F);
        reset = 1'b0;
      end
    end
    tick(4'hF, 7'h7F);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
